branch_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the RISC core. It owns the program counter and the registered N/Z/C flag register, and steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Branch conditions are evaluated against the flags latched by the most recent flag-updating ALU instruction. It sits between instruction memory, the decoder, the ALU and the register file, and asserts their enables.

---
 rtl/branch_sequencer_if.sv | 57 +++++
 rtl/branch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_branch_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// Sequencer-to-datapath bundle: decoder/ALU/memory inputs and sequencer strobes.
// pc_fault exists only when PC_BOUNDS_CHECK_EN is defined.
interface branch_sequencer_if #(
  parameter int unsigned PC_WIDTH = 32
) ();
  logic [1:0]          branch;
  logic [5:0]          function_code;
  logic                is_halt;
  logic                is_mem;
  logic                is_load;
  logic                wb_req;
  logic                flag_update;
  logic                alu_neg;
  logic                alu_zero;
  logic                alu_carry;
  logic [PC_WIDTH-1:0] reg1_value;
  logic [PC_WIDTH-1:0] branch_address;
  logic                mem_ready;

  logic [PC_WIDTH-1:0] pc;
  logic                ir_load;
  logic                alu_en;
  logic                mem_req;
  logic                reg_write;
  logic                link_write;
  logic [4:0]          link_addr;
  logic [PC_WIDTH-1:0] link_data;
  logic                flag_n;
  logic                flag_z;
  logic                flag_c;
  logic                retire;
  logic                halted;
  logic [31:0]         instr_count;
`ifdef PC_BOUNDS_CHECK_EN
  logic                pc_fault;
`endif

  modport master (
    input  branch, function_code, is_halt, is_mem, is_load, wb_req, flag_update,
           alu_neg, alu_zero, alu_carry, reg1_value, branch_address, mem_ready,
    output pc, ir_load, alu_en, mem_req, reg_write, link_write, link_addr, link_data,
           flag_n, flag_z, flag_c, retire, halted, instr_count
`ifdef PC_BOUNDS_CHECK_EN
    , output pc_fault
`endif
  );

  modport slave (
    output branch, function_code, is_halt, is_mem, is_load, wb_req, flag_update,
           alu_neg, alu_zero, alu_carry, reg1_value, branch_address, mem_ready,
    input  pc, ir_load, alu_en, mem_req, reg_write, link_write, link_addr, link_data,
           flag_n, flag_z, flag_c, retire, halted, instr_count
`ifdef PC_BOUNDS_CHECK_EN
    , input pc_fault
`endif
  );
endinterface

// File: rtl/branch_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the PC and N/Z/C flags.
// Define PC_BOUNDS_CHECK_EN to add IMEM_DEPTH and the sticky pc_fault halt.
module branch_sequencer #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned         LINK_REG = 31
`ifdef PC_BOUNDS_CHECK_EN
  , parameter int unsigned       IMEM_DEPTH = 1024
`endif
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  branch_sequencer_if.master  bus
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, br_target, next_pc;
  logic [2:0]          flags_q, flags_d;  // {n, z, c}
  logic [31:0]         cnt_q, cnt_d;
  logic                taken, is_branch, commit;
  logic                ir_load, alu_en, mem_req, reg_write, link_write, retire;
`ifdef PC_BOUNDS_CHECK_EN
  logic                fault_q, fault_d;
`endif

  assign pc_inc    = pc_q + 1'b1;
  assign is_branch = (bus.branch != 2'b00);

  // Conditions use flags_q, i.e. the value before any update in this EXEC cycle.
  always_comb begin
    taken     = 1'b0;
    br_target = bus.branch_address;
    case (bus.branch)
      2'b01: begin
        case (bus.function_code)
          6'd0: begin
            taken     = 1'b1;
            br_target = bus.reg1_value;
          end
          6'd1:    taken = flags_q[2];
          6'd2:    taken = flags_q[1];
          6'd3:    taken = !flags_q[1];
          default: taken = 1'b0;
        endcase
      end
      2'b10: begin
        case (bus.function_code)
          6'd0:    taken = 1'b1;
          6'd1:    taken = flags_q[0];
          6'd2:    taken = !flags_q[0];
          default: taken = 1'b0;
        endcase
      end
      2'b11:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
    next_pc = taken ? br_target : pc_inc;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flags_d    = flags_q;
    commit     = 1'b0;
    retire     = 1'b0;
    ir_load    = 1'b0;
    alu_en     = 1'b0;
    mem_req    = 1'b0;
    reg_write  = 1'b0;
    link_write = 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
    fault_d    = fault_q;
`endif
    case (state_q)
      StFetch: begin
        ir_load = 1'b1;
        state_d = StDecode;
      end
      StDecode: state_d = bus.is_halt ? StHalt : StExec;
      StExec: begin
        alu_en = 1'b1;
        if (bus.flag_update) flags_d = {bus.alu_neg, bus.alu_zero, bus.alu_carry};
        if (is_branch) begin
          link_write = (bus.branch == 2'b11);
          commit     = 1'b1;
        end else if (bus.is_mem) begin
          state_d = StMem;
        end else if (bus.wb_req) begin
          state_d = StWb;
        end else begin
          commit = 1'b1;
        end
      end
      StMem: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          if (bus.is_load) state_d = StWb;
          else             commit  = 1'b1;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        commit    = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase

    if (commit) begin
`ifdef PC_BOUNDS_CHECK_EN
      // An out-of-range target halts the core without moving the PC or retiring.
      if ({1'b0, next_pc} >= (PC_WIDTH+1)'(IMEM_DEPTH)) begin
        fault_d = 1'b1;
        state_d = StHalt;
      end else begin
        pc_d    = next_pc;
        retire  = 1'b1;
        state_d = StFetch;
      end
`else
      pc_d    = next_pc;
      retire  = 1'b1;
      state_d = StFetch;
`endif
    end
    cnt_d = cnt_q + 32'(retire);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      flags_q <= 3'b000;
      cnt_q   <= 32'd0;
`ifdef PC_BOUNDS_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
`ifdef PC_BOUNDS_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  // Strobes are gated by reset so nothing fires while reset is held in FETCH.
  assign bus.pc          = pc_q;
  assign bus.ir_load     = ir_load & rst_ni;
  assign bus.alu_en      = alu_en & rst_ni;
  assign bus.mem_req     = mem_req & rst_ni;
  assign bus.reg_write   = reg_write & rst_ni;
  assign bus.link_write  = link_write & rst_ni;
  assign bus.retire      = retire & rst_ni;
  assign bus.link_addr   = 5'(LINK_REG);
  assign bus.link_data   = pc_inc;
  assign bus.flag_n      = flags_q[2];
  assign bus.flag_z      = flags_q[1];
  assign bus.flag_c      = flags_q[0];
  assign bus.halted      = (state_q == StHalt);
  assign bus.instr_count = cnt_q;
`ifdef PC_BOUNDS_CHECK_EN
  assign bus.pc_fault    = fault_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: a vector table of single instructions
// plus hand-written halt and mid-MEM reset sequences.
module tb_branch_sequencer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  branch_sequencer_if #(.PC_WIDTH(32)) bus ();

  branch_sequencer #(
    .PC_WIDTH(32),
    .RESET_PC(32'd0),
    .LINK_REG(31)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  br;
    logic [5:0]  fc;
    logic [3:0]  ctl;   // {is_mem, is_load, wb_req, flag_update}
    logic [2:0]  alu;   // {neg, zero, carry}
    logic [31:0] r1;
    logic [31:0] ba;
    int          md;    // mem_ready delay in MEM cycles
    int          lat;
    logic [31:0] epc;
    int          rw;
    int          mq;
    int          lw;
    logic [31:0] eld;
    logic [2:0]  ef;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(string nm, logic [1:0] br, logic [5:0] fc, logic [3:0] ctl,
                              logic [2:0] alu, logic [31:0] r1, logic [31:0] ba, int md,
                              int lat, logic [31:0] epc, int rw, int mq, int lw,
                              logic [31:0] eld, logic [2:0] ef);
    vec_t v;
    v.name = nm; v.br = br; v.fc = fc; v.ctl = ctl; v.alu = alu; v.r1 = r1; v.ba = ba;
    v.md = md; v.lat = lat; v.epc = epc; v.rw = rw; v.mq = mq; v.lw = lw; v.eld = eld;
    v.ef = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.branch = 2'b00; bus.function_code = 6'd0; bus.is_halt = 1'b0; bus.is_mem = 1'b0;
    bus.is_load = 1'b0; bus.wb_req = 1'b0; bus.flag_update = 1'b0; bus.alu_neg = 1'b0;
    bus.alu_zero = 1'b0; bus.alu_carry = 1'b0; bus.reg1_value = '0;
    bus.branch_address = '0; bus.mem_ready = 1'b0;
  endtask

  // Called at the negedge of a FETCH cycle; returns at the negedge of the next FETCH.
  task automatic run_vec(input vec_t v, input int exp_cnt);
    int          cyc, rw, mq, lw;
    logic        done;
    logic [31:0] ld;
    {bus.is_mem, bus.is_load, bus.wb_req, bus.flag_update} = v.ctl;
    {bus.alu_neg, bus.alu_zero, bus.alu_carry} = v.alu;
    bus.branch = v.br; bus.function_code = v.fc; bus.is_halt = 1'b0;
    bus.reg1_value = v.r1; bus.branch_address = v.ba;
    bus.mem_ready = (v.md == 0);
    cyc = 0; rw = 0; mq = 0; lw = 0; ld = '0; done = 1'b0;
    #1;
    chk({v.name, ".fetch"}, 64'(bus.ir_load), 64'd1);
    while (!done && cyc < 40) begin
      cyc++;
      if (bus.reg_write) rw++;
      if (bus.mem_req) mq++;
      if (bus.link_write) begin
        lw++;
        ld = bus.link_data;
      end
      if (bus.retire) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        bus.mem_ready = (mq >= v.md);
        #1;
      end
    end
    if (!done) begin
      fails++;
      tests++;
      $display("FAIL %s.timeout: no retire after %0d cycles", v.name, cyc);
    end
    chk({v.name, ".latency"}, 64'(cyc), 64'(v.lat));
    chk({v.name, ".reg_write"}, 64'(rw), 64'(v.rw));
    chk({v.name, ".mem_req"}, 64'(mq), 64'(v.mq));
    chk({v.name, ".link_write"}, 64'(lw), 64'(v.lw));
    if (v.lw != 0) chk({v.name, ".link_data"}, 64'(ld), 64'(v.eld));
    @(negedge clk);
    chk({v.name, ".pc"}, 64'(bus.pc), 64'(v.epc));
    chk({v.name, ".flags"}, 64'({bus.flag_n, bus.flag_z, bus.flag_c}), 64'(v.ef));
    chk({v.name, ".count"}, 64'(bus.instr_count), 64'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] strobes;
    tests = 0;
    fails = 0;
    vecs[0]  = mk("alu_wb0", 2'b00, 6'd0, 4'b0010, 3'b000, 0, 0, 0, 4, 32'h1, 1, 0, 0, 0, 3'b000);
    vecs[1]  = mk("alu_wb1", 2'b00, 6'd0, 4'b0010, 3'b000, 0, 0, 0, 4, 32'h2, 1, 0, 0, 0, 3'b000);
    vecs[2]  = mk("alu_wb2", 2'b00, 6'd0, 4'b0010, 3'b000, 0, 0, 0, 4, 32'h3, 1, 0, 0, 0, 3'b000);
    vecs[3]  = mk("alu_z", 2'b00, 6'd0, 4'b0001, 3'b010, 0, 0, 0, 3, 32'h4, 0, 0, 0, 0, 3'b010);
    vecs[4]  = mk("bz_tk", 2'b01, 6'd2, 4'b0000, 3'b000, 0, 32'h40, 0, 3, 32'h40, 0, 0, 0, 0,
                  3'b010);
    vecs[5]  = mk("bnz_nt", 2'b01, 6'd3, 4'b0000, 3'b000, 0, 32'h80, 0, 3, 32'h41, 0, 0, 0, 0,
                  3'b010);
    vecs[6]  = mk("alu_nc", 2'b00, 6'd0, 4'b0011, 3'b101, 0, 0, 0, 4, 32'h42, 1, 0, 0, 0, 3'b101);
    vecs[7]  = mk("bz_old", 2'b01, 6'd2, 4'b0001, 3'b010, 0, 32'h10, 0, 3, 32'h43, 0, 0, 0, 0,
                  3'b010);
    vecs[8]  = mk("bz_new", 2'b01, 6'd2, 4'b0000, 3'b000, 0, 32'h10, 0, 3, 32'h10, 0, 0, 0, 0,
                  3'b010);
    vecs[9]  = mk("bl", 2'b11, 6'h15, 4'b0000, 3'b000, 0, 32'h80, 0, 3, 32'h80, 0, 0, 1, 32'h11,
                  3'b010);
    vecs[10] = mk("load3", 2'b00, 6'd0, 4'b1100, 3'b000, 0, 0, 3, 8, 32'h81, 1, 4, 0, 0, 3'b010);
    vecs[11] = mk("store0", 2'b00, 6'd0, 4'b1000, 3'b000, 0, 0, 0, 4, 32'h82, 0, 1, 0, 0, 3'b010);
    vecs[12] = mk("br_reg", 2'b01, 6'd0, 4'b0000, 3'b000, 32'h200, 32'h999, 0, 3, 32'h200, 0, 0,
                  0, 0, 3'b010);
    vecs[13] = mk("bltz_nt", 2'b01, 6'd1, 4'b0000, 3'b000, 0, 32'h777, 0, 3, 32'h201, 0, 0, 0, 0,
                  3'b010);
    vecs[14] = mk("bcy_nt", 2'b10, 6'd1, 4'b0000, 3'b000, 0, 32'h777, 0, 3, 32'h202, 0, 0, 0, 0,
                  3'b010);
    vecs[15] = mk("alu_nc2", 2'b00, 6'd0, 4'b0001, 3'b101, 0, 0, 0, 3, 32'h203, 0, 0, 0, 0, 3'b101);
    vecs[16] = mk("bcy_tk", 2'b10, 6'd1, 4'b0000, 3'b000, 0, 32'h300, 0, 3, 32'h300, 0, 0, 0, 0,
                  3'b101);
    vecs[17] = mk("bncy_nt", 2'b10, 6'd2, 4'b0000, 3'b000, 0, 32'h400, 0, 3, 32'h301, 0, 0, 0, 0,
                  3'b101);
    vecs[18] = mk("bltz_tk", 2'b01, 6'd1, 4'b0000, 3'b000, 0, 32'h500, 0, 3, 32'h500, 0, 0, 0, 0,
                  3'b101);
    vecs[19] = mk("b_unc", 2'b10, 6'd0, 4'b0000, 3'b000, 0, 32'h20, 0, 3, 32'h20, 0, 0, 0, 0,
                  3'b101);
    vecs[20] = mk("undef_fc", 2'b01, 6'd5, 4'b0000, 3'b000, 0, 32'h99, 0, 3, 32'h21, 0, 0, 0, 0,
                  3'b101);
    vecs[21] = mk("br_vs_mem", 2'b10, 6'd0, 4'b1010, 3'b000, 0, 32'h30, 0, 3, 32'h30, 0, 0, 0, 0,
                  3'b101);
    vecs[22] = mk("br_max", 2'b01, 6'd0, 4'b0000, 3'b000, 32'hFFFF_FFFF, 0, 0, 3, 32'hFFFF_FFFF,
                  0, 0, 0, 0, 3'b101);
    vecs[23] = mk("alu_wrap", 2'b00, 6'd0, 4'b0010, 3'b000, 0, 0, 0, 4, 32'h0, 1, 0, 0, 0, 3'b101);
    vecs[24] = mk("bl_to5", 2'b11, 6'd0, 4'b0000, 3'b000, 0, 32'h5, 0, 3, 32'h5, 0, 0, 1, 32'h1,
                  3'b101);

    idle_inputs();
    rst_n = 1'b0;
    #12;
    strobes = {bus.ir_load, bus.alu_en, bus.mem_req, bus.reg_write, bus.link_write, bus.retire};
    chk("rst.pc", 64'(bus.pc), 64'd0);
    chk("rst.strobes", 64'(strobes), 64'd0);
    chk("rst.count", 64'(bus.instr_count), 64'd0);
    chk("rst.flags_halted", 64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.halted}), 64'd0);
    chk("rst.link_addr", 64'(bus.link_addr), 64'd31);

    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 25; i++) run_vec(vecs[i], i + 1);

    // Halt at pc=5: no strobes, pc held, for 20 cycles.
    idle_inputs();
    bus.is_halt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      #1;
      strobes = {bus.ir_load, bus.alu_en, bus.mem_req, bus.reg_write, bus.link_write, bus.retire};
      chk("halt.state", 64'({bus.halted, strobes, bus.pc}), {25'd0, 1'b1, 6'd0, 32'h5});
      @(negedge clk);
    end
    chk("halt.count", 64'(bus.instr_count), 64'd25);

    // Reset out of HALT, advance pc, then reset in the middle of a load's MEM stall.
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("halt_rst.halted", 64'(bus.halted), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    run_vec(vecs[0], 1);
    run_vec(vecs[1], 2);
    bus.is_mem = 1'b1;
    bus.is_load = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("mrst.in_mem", 64'(bus.mem_req), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    strobes = {bus.ir_load, bus.alu_en, bus.mem_req, bus.reg_write, bus.link_write, bus.retire};
    chk("mrst.pc_async", 64'(bus.pc), 64'd0);
    chk("mrst.strobes", 64'(strobes), 64'd0);
    chk("mrst.count", 64'(bus.instr_count), 64'd0);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("mrst.no_write", 64'({bus.reg_write, bus.retire}), 64'd0);
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #1 chk("mrst.fetch", 64'({bus.ir_load, bus.mem_req, bus.reg_write}), 64'b100);
    chk("mrst.pc_after", 64'(bus.pc), 64'd0);
    @(negedge clk);  // DECODE
    @(negedge clk);  // EXEC
    bus.mem_ready = 1'b1;
    #1 chk("mrst.exec", 64'(bus.alu_en), 64'd1);
    @(negedge clk);  // MEM, ready on first cycle
    #1 chk("mrst.mem1", 64'(bus.mem_req), 64'd1);
    @(negedge clk);  // WB
    #1 chk("mrst.wb", 64'({bus.reg_write, bus.retire}), 64'b11);
    @(negedge clk);
    chk("mrst.pc_done", 64'(bus.pc), 64'd1);
    chk("mrst.count_done", 64'(bus.instr_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
